// File: rtl/mem_wr_arbiter.sv
// Round-robin write arbiter feeding a single memory write port.
// Grants are combinational; the memory write stage is registered and rejects out-of-range addresses.
module mem_wr_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int LINES_NUM   = 8,
  parameter int DATA_WIDTH  = 4,
  parameter int ADDR_W      = $clog2(LINES_NUM) + 1,
  localparam int ID_W       = $clog2(NUM_CLIENTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_CLIENTS-1:0]            req,
  input  logic [NUM_CLIENTS*ADDR_W-1:0]     req_addr,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]            gnt,
  output logic                              mem_wr_en,
  output logic [ADDR_W-1:0]                 mem_wr_addr,
  output logic [DATA_WIDTH-1:0]             mem_wr_data,
  output logic                              addr_err,
  output logic [ID_W-1:0]                   last_gnt_id
);

  logic [ID_W-1:0]       ptr_r;
  logic [ID_W-1:0]       gnt_id_s;
  logic                  found_s;
  logic [ADDR_W-1:0]     sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic                  in_range_s;
  logic [ID_W-1:0]       ptr_next_s;

  // Round-robin search starting at ptr_r; the first requester found wins.
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    for (int off = 0; off < NUM_CLIENTS; off++) begin
      if (!found_s && req[(int'(ptr_r) + off) % NUM_CLIENTS]) begin
        found_s  = 1'b1;
        gnt_id_s = ID_W'((int'(ptr_r) + off) % NUM_CLIENTS);
      end else begin
        found_s  = found_s;
      end
    end
  end

  // One-hot grant, forced to zero while reset is held.
  always_comb begin
    gnt = '0;
    if (rst && found_s) begin
      gnt[gnt_id_s] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Mux out the winning client's address and data and classify the address.
  always_comb begin
    sel_addr_s = req_addr[int'(gnt_id_s)*ADDR_W +: ADDR_W];
    sel_data_s = req_data[int'(gnt_id_s)*DATA_WIDTH +: DATA_WIDTH];
    in_range_s = (32'(sel_addr_s) < 32'(LINES_NUM));
    if (gnt_id_s == ID_W'(NUM_CLIENTS - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = gnt_id_s + ID_W'(1);
    end
  end

  // Pointer and registered memory write stage; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_r       <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      addr_err    <= 1'b0;
      last_gnt_id <= '0;
    end else if (found_s) begin
      ptr_r       <= ptr_next_s;
      mem_wr_en   <= in_range_s;
      mem_wr_addr <= sel_addr_s;
      mem_wr_data <= sel_data_s;
      addr_err    <= !in_range_s;
      last_gnt_id <= gnt_id_s;
    end else begin
      mem_wr_en   <= 1'b0;
      addr_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Scoreboard bench for mem_wr_arbiter: a reference round-robin model predicts grants
// and the registered write stage, and a small memory array records the writes.
module tb_mem_wr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        mem_wr_en;
  logic [3:0]  mem_wr_addr;
  logic [3:0]  mem_wr_data;
  logic        addr_err;
  logic [1:0]  last_gnt_id;

  typedef struct packed {
    logic       en;
    logic [3:0] addr;
    logic [3:0] data;
    logic       err;
    logic [1:0] id;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] mem [8];
  logic [3:0] exp_mem [8];
  int         total = 0;
  int         bad   = 0;
  int         m_ptr;
  logic [3:0] m_addr, m_data;
  logic [1:0] m_last;
  logic       pend_en;
  logic [2:0] pend_addr;
  logic [3:0] pend_data;

  mem_wr_arbiter #(.NUM_CLIENTS(4), .LINES_NUM(8), .DATA_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .addr_err(addr_err), .last_gnt_id(last_gnt_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model driven by the arbiter's write port.
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr[2:0]] <= mem_wr_data;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_mem();
    for (int i = 0; i < 8; i++) check_val($sformatf("mem[%0d]", i), 32'(mem[i]), 32'(exp_mem[i]));
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_addr  = 4'h0;
    m_data  = 4'h0;
    m_last  = 2'd0;
    pend_en = 1'b0;
    sb.delete();
  endtask

  // One cycle: drive, predict and check gnt, push expectation, clock, pop and compare.
  task automatic step(input logic [3:0] r, input logic [15:0] a, input logic [15:0] d);
    int   k;
    exp_t it;
    exp_t got;
    req = r; req_addr = a; req_data = d;
    #1;
    k = -1;
    for (int off = 0; off < 4; off++) begin
      if (k < 0 && r[(m_ptr + off) % 4]) k = (m_ptr + off) % 4;
    end
    check_val("gnt", 32'(gnt), (k < 0) ? 32'd0 : (32'd1 << k));
    if (k >= 0) begin
      m_addr = a[k*4 +: 4];
      m_data = d[k*4 +: 4];
      m_last = 2'(k);
      m_ptr  = (k + 1) % 4;
      it = '{en: (m_addr < 4'd8), addr: m_addr, data: m_data, err: (m_addr >= 4'd8), id: m_last};
    end else begin
      it = '{en: 1'b0, addr: m_addr, data: m_data, err: 1'b0, id: m_last};
    end
    sb.push_back(it);
    @(posedge clk);
    if (pend_en) exp_mem[pend_addr] = pend_data;
    #1;
    it  = sb.pop_front();
    got = '{en: mem_wr_en, addr: mem_wr_addr, data: mem_wr_data, err: addr_err, id: last_gnt_id};
    check_val("wr_en", 32'(got.en), 32'(it.en));
    check_val("wr_addr", 32'(got.addr), 32'(it.addr));
    check_val("wr_data", 32'(got.data), 32'(it.data));
    check_val("addr_err", 32'(got.err), 32'(it.err));
    check_val("last_id", 32'(got.id), 32'(it.id));
    pend_en   = it.en;
    pend_addr = it.addr[2:0];
    pend_data = it.data;
  endtask

  // Hold reset with every client requesting; everything must read zero.
  task automatic hold_reset();
    rst = 1'b0;
    req = 4'b1111;
    #1;
    check_val("rst_gnt", 32'(gnt), 32'd0);
    check_val("rst_wr_en", 32'(mem_wr_en), 32'd0);
    check_val("rst_addr", 32'(mem_wr_addr), 32'd0);
    check_val("rst_data", 32'(mem_wr_data), 32'd0);
    check_val("rst_err", 32'(addr_err), 32'd0);
    check_val("rst_last", 32'(last_gnt_id), 32'd0);
    @(posedge clk);
    #1;
    check_val("rst_gnt_hold", 32'(gnt), 32'd0);
    model_reset();
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] ra, rd;
    for (int i = 0; i < 8; i++) begin
      mem[i]     = 4'h0;
      exp_mem[i] = 4'h0;
    end
    rst = 1'b0; req = 4'b0000; req_addr = 16'h0; req_data = 16'h0;
    @(posedge clk);
    #1;
    // Reset, then the first grant goes to client 0.
    hold_reset();
    step(4'b1111, 16'h7531, 16'h4321);
    // Single client 2 writes line 3 with 0xA.
    step(4'b0100, 16'h0300, 16'h0A00);
    step(4'b0000, 16'h0000, 16'h0000);
    check_mem();
    // Full contention for 8 cycles from a fresh pointer.
    hold_reset();
    for (int i = 0; i < 8; i++) step(4'b1111, 16'h6420, 16'hDCBA + 16'(i));
    // Pointer skip: grant 1 leaves ptr=2; then 0 wins, then 1.
    step(4'b0010, 16'h0010, 16'h0050);
    step(4'b0011, 16'h0012, 16'h0061);
    step(4'b0010, 16'h0040, 16'h0090);
    // Bad address from client 3: flagged, memory untouched.
    step(4'b1000, 16'h8000, 16'hF000);
    step(4'b0000, 16'h0000, 16'h0000);
    check_mem();
    // Reset one cycle after a grant: write to line 5 must be discarded.
    step(4'b0001, 16'h0005, 16'h0007);
    check_val("pre_rst_wr_en", 32'(mem_wr_en), 32'd1);
    hold_reset();
    check_val("mem5_after_rst", 32'(mem[5]), 32'(exp_mem[5]));
    step(4'b1111, 16'h1111, 16'h2222);
    // Random traffic, including withdrawn requests and out-of-range addresses.
    for (int i = 0; i < 40; i++) begin
      for (int c = 0; c < 4; c++) begin
        ra[c*4 +: 4] = 4'($urandom_range(0, 9));
        rd[c*4 +: 4] = 4'($urandom_range(0, 15));
      end
      step(4'($urandom_range(0, 15)), ra, rd);
    end
    step(4'b0000, 16'h0000, 16'h0000);
    check_mem();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
